// File: rtl/cv32e41s_clic_int_ctrl_mp.sv
// rtl/cv32e41s_clic_int_ctrl_mp.sv - CLIC interrupt holding, eligibility and handshake controller
module cv32e41s_clic_int_ctrl_mp #(
  parameter int CLIC_ID_WIDTH = 5,
  parameter int USER_MODE_EN  = 1
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     clic_irq_i,
  input  logic [CLIC_ID_WIDTH-1:0] clic_irq_id_i,
  input  logic [7:0]               clic_irq_level_i,
  input  logic [1:0]               clic_irq_priv_i,
  input  logic                     clic_irq_shv_i,
  output logic                     clic_irq_ack_o,

  input  logic                     irq_ack_i,
  output logic                     irq_req_ctrl_o,
  output logic [9:0]               irq_id_ctrl_o,
  output logic                     irq_wu_ctrl_o,
  output logic                     irq_clic_shv_o,
  output logic [7:0]               irq_clic_level_o,
  output logic [1:0]               irq_clic_priv_o,

  input  logic                     mstatus_mie_i,
  input  logic                     mstatus_uie_i,
  input  logic [7:0]               mintthresh_i,
  input  logic [7:0]               uintthresh_i,
  input  logic [7:0]               mil_i,
  input  logic [7:0]               uil_i,
  input  logic [7:0]               mpil_i,
  input  logic [1:0]               priv_lvl_i,
  output logic                     mnxti_irq_pending_o,
  output logic [CLIC_ID_WIDTH-1:0] mnxti_irq_id_o,
  output logic [7:0]               mnxti_irq_level_o
);

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HELD  = 2'b01,
    ACKED = 2'b10
  } state_t;

  state_t                   state_q;
  logic [CLIC_ID_WIDTH-1:0] id_q;
  logic [7:0]               level_q;
  logic                     shv_q;
  logic [1:0]               priv_q;

  logic [1:0]               in_target;
  logic                     take;
  logic                     capture;

  // Shared eligibility rule; the gate inputs let wake-up ignore the global enables.
  function automatic logic eligible(
    input logic [1:0] target,
    input logic [7:0] level,
    input logic       gate_m,
    input logic       gate_u,
    input logic [1:0] priv_lvl,
    input logic [7:0] mth,
    input logic [7:0] mil,
    input logic [7:0] uth,
    input logic [7:0] uil
  );
    logic [7:0] m_floor;
    logic [7:0] u_floor;
    logic       result;
    m_floor = (mth > mil) ? mth : mil;
    u_floor = (uth > uil) ? uth : uil;
    if (target == PRIV_M) begin
      if (priv_lvl == PRIV_M) result = gate_m && (level > m_floor);
      else                    result = (level != 8'd0);
    end else begin
      // A U-targeted interrupt can only be taken while running in U-mode.
      if (priv_lvl == PRIV_U) result = gate_u && (level > u_floor);
      else                    result = 1'b0;
    end
    return result;
  endfunction

  // Target privilege of the incoming interrupt; without U-mode everything goes to M.
  always_comb begin
    in_target = PRIV_M;
    if ((USER_MODE_EN != 0) && (clic_irq_priv_i == PRIV_U)) in_target = PRIV_U;
  end

  // Request to the controller, wake-up and the take/capture decisions.
  always_comb begin
    irq_req_ctrl_o = (state_q == HELD) &&
                     eligible(priv_q, level_q, mstatus_mie_i, mstatus_uie_i, priv_lvl_i,
                              mintthresh_i, mil_i, uintthresh_i, uil_i);
    irq_wu_ctrl_o  = clic_irq_i &&
                     eligible(in_target, clic_irq_level_i, 1'b1, 1'b1, priv_lvl_i,
                              mintthresh_i, mil_i, uintthresh_i, uil_i);
    take           = irq_ack_i && irq_req_ctrl_o;
    capture        = clic_irq_i && ((state_q == IDLE) || ((state_q == HELD) && !take));
  end

  // Handshake state machine: a take wins over both replacement and withdrawal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (clic_irq_i) state_q <= HELD;
        HELD: begin
          if (take)             state_q <= ACKED;
          else if (!clic_irq_i) state_q <= IDLE;
        end
        ACKED:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Held interrupt fields; kept unchanged on withdrawal so the last ID stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      level_q <= 8'd0;
      shv_q   <= 1'b0;
      priv_q  <= PRIV_M;
    end else if (capture) begin
      id_q    <= clic_irq_id_i;
      level_q <= clic_irq_level_i;
      shv_q   <= clic_irq_shv_i;
      priv_q  <= in_target;
    end
  end

  // Outputs derived from the held fields and state.
  always_comb begin
    clic_irq_ack_o                     = (state_q == ACKED);
    irq_id_ctrl_o                      = '0;
    irq_id_ctrl_o[CLIC_ID_WIDTH-1:0]   = id_q;
    irq_clic_shv_o                     = shv_q;
    irq_clic_level_o                   = level_q;
    irq_clic_priv_o                    = priv_q;
    mnxti_irq_pending_o                = (state_q == HELD) && (priv_q == PRIV_M) &&
                                         (level_q > mpil_i) && (level_q > mintthresh_i) &&
                                         !shv_q;
    mnxti_irq_id_o                     = id_q;
    mnxti_irq_level_o                  = level_q;
  end

endmodule
